// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the instruction memory
// address, and registers fetched words into the IF/ID pipeline register.
// A two-state FSM (BOOT/RUN) inserts one idle cycle after reset before
// the first fetch. Redirects flush IF/ID and take priority over stalls.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic        take_redirect;
  logic        take_fetch;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] npc_reg, npc_next;
  logic        valid_reg, valid_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] pc_plus1;

  // PC+1 wraps naturally at 2^32
  assign pc_plus1 = pc_reg + 32'd1;

  // FSM state register; reset always lands in BOOT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= BOOT;
    else     state_reg <= state_next;
  end

  // FSM next state: BOOT lasts exactly one edge, with or without redirect
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // FSM outputs: redirect wins in any state; fetch only in RUN when not stalled
  always_comb begin
    take_redirect = 1'b0;
    take_fetch    = 1'b0;
    case (state_reg)
      BOOT: take_redirect = redirect;
      RUN: begin
        take_redirect = redirect;
        take_fetch    = !redirect && !stall;
      end
      default: ;
    endcase
  end

  // Datapath next values; every register is rewritten each cycle (hold = own value)
  always_comb begin
    pc_next    = pc_reg;
    instr_next = instr_reg;
    npc_next   = npc_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    if (take_redirect) begin
      pc_next    = redirect_pc;
      instr_next = NOP_WORD;
      npc_next   = 32'd0;
      valid_next = 1'b0;
    end else if (take_fetch) begin
      pc_next    = pc_plus1;
      instr_next = imem_data;
      npc_next   = pc_plus1;
      valid_next = 1'b1;
      count_next = (count_reg == 32'hFFFF_FFFF) ? count_reg : count_reg + 32'd1;
    end
  end

  // Datapath registers with asynchronous reset to the bubble state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_WORD;
      npc_reg   <= 32'd0;
      valid_reg <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      npc_reg   <= npc_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign if_id_instr = instr_reg;
  assign if_id_npc   = npc_reg;
  assign if_id_valid = valid_reg;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: behavioural model of the fetch rules, per-cycle
// comparison on the falling edge, directed scenarios with literal
// expectations, then a randomized phase.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:127];

  int n_chk = 0;
  int n_err = 0;
  logic hold_cmp = 1'b0;
  logic load_count = 1'b0;

  // model state
  logic        m_started;
  logic [31:0] m_pc, m_instr, m_npc, m_count;
  logic        m_valid;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[6:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch rules applied at each rising edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started <= 1'b0;
      m_pc      <= 32'h0;
      m_instr   <= NOP;
      m_npc     <= 32'h0;
      m_valid   <= 1'b0;
      m_count   <= 32'h0;
    end else begin
      m_started <= 1'b1;
      if (redirect) begin
        m_pc    <= redirect_pc;
        m_instr <= NOP;
        m_npc   <= 32'h0;
        m_valid <= 1'b0;
      end else if (m_started && !stall) begin
        m_pc    <= m_pc + 32'd1;
        m_instr <= mem[m_pc[6:0]];
        m_npc   <= m_pc + 32'd1;
        m_valid <= 1'b1;
        m_count <= (m_count == 32'hFFFF_FFFF) ? m_count : m_count + 32'd1;
      end
      if (load_count) m_count <= 32'hFFFF_FFFE;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!hold_cmp) begin
      check("imem_addr", imem_addr, m_pc);
      check("if_id_instr", if_id_instr, m_instr);
      check("if_id_npc", if_id_npc, m_npc);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      check("fetch_count", fetch_count, m_count);
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0]  = 32'h8C01_0001;
    mem[1]  = 32'h8C02_0002;
    mem[2]  = 32'h8C03_0003;
    mem[18] = 32'h0020_0820;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    check("reset_instr", if_id_instr, NOP);
    check("reset_addr", imem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // BOOT cycle then sequential fetches
    @(negedge clk);
    check("boot_addr", imem_addr, 32'h0);
    check("boot_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    check("f1_instr", if_id_instr, 32'h8C01_0001);
    check("f1_npc", if_id_npc, 32'd1);
    check("f1_valid", {31'd0, if_id_valid}, 32'd1);
    check("f1_count", fetch_count, 32'd1);
    @(negedge clk);
    check("f2_instr", if_id_instr, 32'h8C02_0002);
    check("f2_npc", if_id_npc, 32'd2);
    check("f2_count", fetch_count, 32'd2);

    // stall for three edges
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_instr", if_id_instr, 32'h8C02_0002);
      check("stall_addr", imem_addr, 32'd2);
      check("stall_count", fetch_count, 32'd2);
    end
    stall = 1'b0;
    @(negedge clk);
    check("resume_instr", if_id_instr, 32'h8C03_0003);
    check("resume_count", fetch_count, 32'd3);

    // redirect beats stall
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0012;
    @(negedge clk);
    check("redir_addr", imem_addr, 32'd18);
    check("redir_instr", if_id_instr, NOP);
    check("redir_valid", {31'd0, if_id_valid}, 32'd0);
    check("redir_count", fetch_count, 32'd3);
    redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("tgt_instr", if_id_instr, 32'h0020_0820);
    check("tgt_npc", if_id_npc, 32'd19);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_npc", if_id_npc, 32'd0);
    check("wrap_addr", imem_addr, 32'd0);
    check("wrap_instr", if_id_instr, mem[127]);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("arst_addr", imem_addr, 32'd0);
    check("arst_instr", if_id_instr, NOP);
    check("arst_npc", if_id_npc, 32'd0);
    check("arst_valid", {31'd0, if_id_valid}, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0040;
    @(negedge clk);
    check("rst_ignores_redirect", imem_addr, 32'd0);
    redirect = 1'b0; stall = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("reboot_valid", {31'd0, if_id_valid}, 32'd0);
    check("reboot_count", fetch_count, 32'd0);
    @(negedge clk);
    check("refetch_instr", if_id_instr, 32'h8C01_0001);
    check("refetch_count", fetch_count, 32'd1);

    // fetch_count saturation
    stall = 1'b1;
    @(posedge clk);
    #1;
    hold_cmp = 1'b1;
    load_count = 1'b1;
    force dut.count_reg = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.count_reg;
    load_count = 1'b0;
    hold_cmp = 1'b0;
    @(negedge clk);
    check("sat_start", fetch_count, 32'hFFFF_FFFE);
    stall = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("sat_count", fetch_count, 32'hFFFF_FFFF);
    end

    // randomized phase
    for (int c = 0; c < 600; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 200));
      rst         = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
